// File: rtl/div_if.sv
// Handshake and result bundle between the EX stage and the divide sequencer.
// EX drives the request side (master); div_ctrl answers with stall/ready/results (slave).
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             annul;
  logic             stallreq;
  logic             ready;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;

  modport master (
    output start, signed_div, op_a, op_b, annul,
    input  stallreq, ready, result_lo, result_hi
  );

  modport slave (
    input  start, signed_div, op_a, op_b, annul,
    output stallreq, ready, result_lo, result_hi
  );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: stalls the pipeline while busy
// and presents quotient (LO) / remainder (HI) with a single-cycle ready pulse.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH-1:0] dvs_reg, dvs_next;
  logic [WIDTH-1:0] dividend_reg, dividend_next;
  logic             neg_quo_reg, neg_quo_next;
  logic             neg_rem_reg, neg_rem_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [WIDTH-1:0] hi_reg, hi_next;

  // One restoring step: remainder needs a spare bit after the shift.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, dvs_reg};
    rem_ge    = (rem_shift >= {1'b0, dvs_reg});
    step_rem  = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    step_quo  = {quo_reg[WIDTH-2:0], rem_ge};
  end

  // Magnitudes of the incoming operands; 0x80000000 maps onto itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    mag_a = (bus.signed_div && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
    mag_b = (bus.signed_div && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    rem_next      = rem_reg;
    quo_next      = quo_reg;
    dvs_next      = dvs_reg;
    dividend_next = dividend_reg;
    neg_quo_next  = neg_quo_reg;
    neg_rem_next  = neg_rem_reg;
    lo_next       = lo_reg;
    hi_next       = hi_reg;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (bus.start && !bus.annul) begin
          dividend_next = bus.op_a;
          dvs_next      = mag_b;
          quo_next      = mag_a;
          rem_next      = '0;
          neg_quo_next  = bus.signed_div && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
          neg_rem_next  = bus.signed_div && bus.op_a[WIDTH-1];
          state_next    = (bus.op_b == '0) ? DIVZERO : ON;
        end
      end

      DIVZERO: begin
        state_next = END;
        lo_next    = '1;
        hi_next    = dividend_reg;
      end

      ON: begin
        rem_next = step_rem;
        quo_next = step_quo;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          state_next = END;
          lo_next    = neg_quo_reg ? -step_quo : step_quo;
          hi_next    = neg_rem_reg ? -step_rem : step_rem;
        end
      end

      END: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Flush overrides everything: back to IDLE without touching the results.
    if (bus.annul) begin
      state_next = IDLE;
      cnt_next   = '0;
      lo_next    = lo_reg;
      hi_next    = hi_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      dvs_reg      <= '0;
      dividend_reg <= '0;
      neg_quo_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      lo_reg       <= '0;
      hi_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rem_reg      <= rem_next;
      quo_reg      <= quo_next;
      dvs_reg      <= dvs_next;
      dividend_reg <= dividend_next;
      neg_quo_reg  <= neg_quo_next;
      neg_rem_reg  <= neg_rem_next;
      lo_reg       <= lo_next;
      hi_reg       <= hi_next;
    end
  end

  // Stall drops in END so the stalled instruction advances on the ready cycle.
  assign bus.stallreq  = !bus.annul &&
                         (((state_reg == IDLE) && bus.start) ||
                          (state_reg == DIVZERO) || (state_reg == ON));
  assign bus.ready     = (state_reg == END) && !bus.annul;
  assign bus.result_lo = lo_reg;
  assign bus.result_hi = hi_reg;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed and random divides, divide-by-zero,
// annul and mid-operation reset, with a scoreboard matched against ready pulses.
module tb_div_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  div_if #(.WIDTH(32)) bus ();

  div_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] prev_lo = '0;
  logic [31:0] prev_hi = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference from plain SV arithmetic; the signed overflow case is pinned explicitly.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                output logic [31:0] lo, output logic [31:0] hi);
    if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (!sgn) begin
      lo = a / b;
      hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000;
      hi = 32'd0;
    end else begin
      lo = 32'($signed(a) / $signed(b));
      hi = 32'($signed(a) % $signed(b));
    end
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    #2;
    if (bus.ready) begin
      if (sb.size() == 0) begin
        chk("spurious_ready", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("result_lo", 64'(bus.result_lo), 64'(mon_e.lo));
        chk("result_hi", 64'(bus.result_hi), 64'(mon_e.hi));
        chk("ready_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // Drives one divide starting at the next negedge and checks stall/ready per cycle.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [31:0] lo, input logic [31:0] hi,
                        input int lat, input logic hold);
    exp_t e;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.op_a       = a;
    bus.op_b       = b;
    bus.signed_div = sgn;
    e.lo  = lo;
    e.hi  = hi;
    e.cyc = cyc + lat;
    sb.push_back(e);
    #1;
    chk("stall_c0", 64'(bus.stallreq), 64'd1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      bus.op_a = ~a;
      bus.op_b = b ^ 32'h5A5A_0001;
      #1;
      chk($sformatf("stall_c%0d", k), 64'(bus.stallreq), (k < lat) ? 64'd1 : 64'd0);
      chk($sformatf("ready_c%0d", k), 64'(bus.ready), (k == lat) ? 64'd1 : 64'd0);
    end
    bus.start = 1'b0;
    prev_lo   = lo;
    prev_hi   = hi;
    $display("div a=%h b=%h signed=%0d -> lo=%h hi=%h", a, b, sgn, bus.result_lo, bus.result_hi);
  endtask

  initial begin
    logic [31:0] ra, rb, rlo, rhi;
    logic        rs;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.op_a       = '0;
    bus.op_b       = '0;
    bus.annul      = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", 64'(bus.stallreq), 64'd0);
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_lo", 64'(bus.result_lo), 64'd0);
    chk("rst_hi", 64'(bus.result_hi), 64'd0);
    rst = 1'b0;

    do_div(32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 32'h0FFF_FFFF, 32'h0000_000F, 33, 1'b1);
    do_div(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);
    do_div(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h0000_0001, 33, 1'b0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000, 33, 1'b0);
    do_div(32'h1234_5678, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 2, 1'b0);
    do_div(32'h8765_4321, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'h8765_4321, 2, 1'b0);

    // Annul at cycle 10: no ready, results kept, new start at cycle 12.
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 32'd1000; bus.op_b = 32'd7; bus.signed_div = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      bus.start = (k == 3 || k == 5);
      #1;
      chk("annul_busy_stall", 64'(bus.stallreq), 64'd1);
    end
    @(negedge clk);
    bus.start = 1'b0; bus.annul = 1'b1;
    #1;
    chk("annul_stall", 64'(bus.stallreq), 64'd0);
    chk("annul_ready", 64'(bus.ready), 64'd0);
    @(negedge clk);
    bus.annul = 1'b0;
    #1;
    chk("annul_idle_stall", 64'(bus.stallreq), 64'd0);
    chk("annul_keep_lo", 64'(bus.result_lo), 64'(prev_lo));
    chk("annul_keep_hi", 64'(bus.result_hi), 64'(prev_hi));
    $display("annul at cycle 10 -> lo=%h hi=%h", bus.result_lo, bus.result_hi);
    do_div(32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 33, 1'b0);

    // Annul together with start in IDLE: start must not be accepted.
    @(negedge clk);
    bus.start = 1'b1; bus.annul = 1'b1;
    #1;
    chk("annul_start_stall", 64'(bus.stallreq), 64'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.annul = 1'b0;
    #1;
    chk("annul_start_idle", 64'(bus.stallreq), 64'd0);

    // Reset at cycle 5 with start toggling during ON.
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 32'hDEAD_BEEF; bus.op_b = 32'd3; bus.signed_div = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.start = k[0];
    end
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    #1;
    chk("mrst_stall", 64'(bus.stallreq), 64'd0);
    chk("mrst_ready", 64'(bus.ready), 64'd0);
    chk("mrst_lo", 64'(bus.result_lo), 64'd0);
    chk("mrst_hi", 64'(bus.result_hi), 64'd0);
    $display("reset mid-divide -> lo=%h hi=%h", bus.result_lo, bus.result_hi);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      rs = i[0];
      model(ra, rb, rs, rlo, rhi);
      do_div(ra, rb, rs, rlo, rhi, (rb == 32'd0) ? 2 : 33, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
